// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM result (load extract/extend, ALU/load/link select)
// and arbitrates the register-file write port against a one-entry multiply result buffer.
module wb_stage #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_dest,
  input  logic [1:0]  mem_wb_sel,
  input  logic [31:0] mem_alu_result,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_link_addr,
  input  logic [2:0]  mem_load_type,
  input  logic        md_valid,
  input  logic [4:0]  md_dest,
  input  logic [31:0] md_data,
  output logic        md_ready,
  output logic        wb_stall_req,
  output logic        rf_write_en,
  output logic [4:0]  rf_write_num,
  output logic [31:0] rf_write_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // Handshake: a multiply result transfers on a posedge where md_valid && md_ready.
  // md_ready depends only on buffer occupancy and rst, never on md_valid.

  logic        buf_full;
  logic [4:0]  buf_dest;
  logic [31:0] buf_data;
  logic [3:0]  starve_cnt;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] pipe_data;
  logic        pipe_qual;
  logic        drain;
  logic        drop;
  logic        accept;

  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (mem_alu_result[1:0])
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    // Halfword alignment is trapped upstream, so bit 0 of the offset is ignored.
    ld_half = mem_alu_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mem_load_type)
      3'd0:    load_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    load_data = {24'd0, ld_byte};
      3'd2:    load_data = {{16{ld_half[15]}}, ld_half};
      3'd3:    load_data = {16'd0, ld_half};
      default: load_data = mem_rdata;
    endcase
    case (mem_wb_sel)
      2'd1:    pipe_data = load_data;
      2'd2:    pipe_data = mem_link_addr;
      default: pipe_data = mem_alu_result;
    endcase
  end

  assign pipe_qual    = mem_valid && mem_reg_write && (mem_dest != 5'd0);
  assign drain        = buf_full && !pipe_qual;
  // A younger pipe write to the same register makes the buffered result dead.
  assign drop         = buf_full && pipe_qual && (mem_dest == buf_dest);
  assign md_ready     = !buf_full && !rst;
  assign accept       = md_valid && md_ready;
  assign wb_stall_req = buf_full && (starve_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write_en   <= 1'b0;
      rf_write_num  <= 5'd0;
      rf_write_data <= 32'd0;
      buf_full      <= 1'b0;
      buf_dest      <= 5'd0;
      buf_data      <= 32'd0;
      starve_cnt    <= 4'd0;
    end else begin
      if (pipe_qual) begin
        rf_write_en   <= 1'b1;
        rf_write_num  <= mem_dest;
        rf_write_data <= pipe_data;
      end else if (buf_full) begin
        rf_write_en   <= 1'b1;
        rf_write_num  <= buf_dest;
        rf_write_data <= buf_data;
      end else begin
        rf_write_en   <= 1'b0;
      end

      if (drain || drop) begin
        buf_full   <= 1'b0;
        starve_cnt <= 4'd0;
      end else if (accept && (md_dest != 5'd0)) begin
        buf_full   <= 1'b1;
        buf_dest   <= md_dest;
        buf_data   <= md_data;
        starve_cnt <= 4'd0;
      end else if (buf_full && (starve_cnt != LIMIT)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized mix, with a write-port
// scoreboard fed at drive time and drained by a monitor one cycle later.
module tb_wb_stage;

  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_reg_write = 1'b0;
  logic [4:0]  mem_dest = '0;
  logic [1:0]  mem_wb_sel = '0;
  logic [31:0] mem_alu_result = '0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_link_addr = '0;
  logic [2:0]  mem_load_type = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_dest = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        wb_stall_req;
  logic        rf_write_en;
  logic [4:0]  rf_write_num;
  logic [31:0] rf_write_data;

  int vectors = 0;
  int errors  = 0;
  logic [36:0] exp_q[$];

  // bench-side model of the multiply buffer for the random scenario
  logic        mdl_full;
  logic [4:0]  mdl_dest;
  logic [31:0] mdl_data;

  wb_stage #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_dest(mem_dest),
    .mem_wb_sel(mem_wb_sel), .mem_alu_result(mem_alu_result), .mem_rdata(mem_rdata),
    .mem_link_addr(mem_link_addr), .mem_load_type(mem_load_type),
    .md_valid(md_valid), .md_dest(md_dest), .md_data(md_data), .md_ready(md_ready),
    .wb_stall_req(wb_stall_req), .rf_write_en(rf_write_en),
    .rf_write_num(rf_write_num), .rf_write_data(rf_write_data)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // write-port monitor: every emitted write must match the head of the scoreboard
  always begin
    @(posedge clk);
    #1;
    if (rf_write_en === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got num=%0d data=%h, required no write",
                 rf_write_num, rf_write_data);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({rf_write_num, rf_write_data} !== e) begin
          errors++;
          $display("FAIL wb_write: got num=%0d data=%h, required num=%0d data=%h",
                   rf_write_num, rf_write_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  // driver tasks
  task automatic set_pipe(input logic v, input logic rw, input logic [4:0] dest,
                          input logic [1:0] sel, input logic [31:0] alu,
                          input logic [31:0] rdata, input logic [31:0] link,
                          input logic [2:0] lt);
    mem_valid = v; mem_reg_write = rw; mem_dest = dest; mem_wb_sel = sel;
    mem_alu_result = alu; mem_rdata = rdata; mem_link_addr = link; mem_load_type = lt;
  endtask

  task automatic set_md(input logic v, input logic [4:0] dest, input logic [31:0] data);
    md_valid = v; md_dest = dest; md_data = data;
  endtask

  task automatic clear_inputs();
    set_pipe(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 3'd0);
    set_md(1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors += 5;
    if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b required 0", rf_write_en); end
    if (rf_write_num !== 5'd0) begin errors++; $display("FAIL reset_num: got %0d required 0", rf_write_num); end
    if (rf_write_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h required 0", rf_write_data); end
    if (wb_stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", wb_stall_req); end
    if (md_ready !== 1'b0) begin errors++; $display("FAIL reset_md_ready_in_rst: got %b required 0", md_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors += 2;
    if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready_after: got %b required 1", md_ready); end
    if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_en_after: got %b required 0", rf_write_en); end
  endtask

  task automatic test_loads();
    logic [2:0]  lt_tab[10]  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2, 3'd1, 3'd4, 3'd3, 3'd6};
    logic [1:0]  off_tab[10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1, 2'd2};
    logic [31:0] exp_tab[10] = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                                 32'h000080FF, 32'hFFFF80FF, 32'h00000080, 32'h80FF7F01,
                                 32'h00007F01, 32'h80FF7F01};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_pipe(1'b1, 1'b1, 5'(i + 1), 2'd1, {30'h1000, off_tab[i]}, 32'h80FF7F01,
               32'h0, lt_tab[i]);
      exp_q.push_back({5'(i + 1), exp_tab[i]});
      @(posedge clk);
      #1;
      vectors++;
      if (rf_write_en !== 1'b1) begin
        errors++;
        $display("FAIL load_latency[%0d]: got en=%b required 1", i, rf_write_en);
      end
    end
    // link select, and the reserved select falling back to the ALU result
    @(negedge clk);
    set_pipe(1'b1, 1'b1, 5'd31, 2'd2, 32'h1111, 32'h2222, 32'h00400008, 3'd4);
    exp_q.push_back({5'd31, 32'h00400008});
    @(negedge clk);
    set_pipe(1'b1, 1'b1, 5'd12, 2'd3, 32'hCAFE0001, 32'h2222, 32'h3333, 3'd0);
    exp_q.push_back({5'd12, 32'hCAFE0001});
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
  endtask

  task automatic test_zero_dest();
    @(negedge clk);
    set_pipe(1'b1, 1'b1, 5'd0, 2'd0, 32'h12345678, 32'h0, 32'h0, 3'd4);
    set_md(1'b1, 5'd0, 32'h87654321);
    @(posedge clk);
    #1;
    vectors += 2;
    if (rf_write_en !== 1'b0) begin errors++; $display("FAIL zero_dest_en: got %b required 0", rf_write_en); end
    if (md_ready !== 1'b1) begin errors++; $display("FAIL zero_dest_buffer: got md_ready=%b required 1", md_ready); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    vectors++;
    if (rf_write_en !== 1'b0) begin errors++; $display("FAIL zero_dest_no_drain: got en=%b required 0", rf_write_en); end
  endtask

  task automatic test_idle_drain();
    @(negedge clk);
    set_md(1'b1, 5'd5, 32'hDEADBEEF);
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(posedge clk);
    #1;
    vectors++;
    if (md_ready !== 1'b0) begin errors++; $display("FAIL idle_drain_ready_low: got %b required 0", md_ready); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #1;
    vectors += 2;
    if (md_ready !== 1'b1) begin errors++; $display("FAIL idle_drain_ready_back: got %b required 1", md_ready); end
    if (rf_write_en !== 1'b1) begin errors++; $display("FAIL idle_drain_latency: got en=%b required 1", rf_write_en); end
  endtask

  task automatic test_starvation();
    for (int i = 0; i <= int'(STARVE_LIMIT); i++) begin
      @(negedge clk);
      set_pipe(1'b1, 1'b1, 5'd3, 2'd0, 32'h30000000 + 32'(i), 32'h0, 32'h0, 3'd4);
      if (i == 0) set_md(1'b1, 5'd7, 32'hA5A5A5A5);
      else set_md(1'b0, 5'd0, 32'd0);
      exp_q.push_back({5'd3, 32'h30000000 + 32'(i)});
      @(posedge clk);
      #1;
      vectors++;
      if (wb_stall_req !== (i == int'(STARVE_LIMIT))) begin
        errors++;
        $display("FAIL starve_stall[%0d]: got %b required %b", i, wb_stall_req,
                 i == int'(STARVE_LIMIT));
      end
    end
    // the bubble upstream owes us
    @(negedge clk);
    clear_inputs();
    exp_q.push_back({5'd7, 32'hA5A5A5A5});
    @(posedge clk);
    #1;
    vectors += 2;
    if (wb_stall_req !== 1'b0) begin errors++; $display("FAIL starve_stall_clear: got %b required 0", wb_stall_req); end
    if (md_ready !== 1'b1) begin errors++; $display("FAIL starve_ready: got %b required 1", md_ready); end
  endtask

  task automatic test_waw_drop();
    @(negedge clk);
    set_md(1'b1, 5'd9, 32'h11111111);
    @(negedge clk);
    set_md(1'b0, 5'd0, 32'd0);
    set_pipe(1'b1, 1'b1, 5'd9, 2'd0, 32'h22222222, 32'h0, 32'h0, 3'd4);
    exp_q.push_back({5'd9, 32'h22222222});
    @(posedge clk);
    #1;
    vectors++;
    if (md_ready !== 1'b1) begin errors++; $display("FAIL waw_ready: got %b required 1", md_ready); end
    @(negedge clk);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (rf_write_en !== 1'b0) begin errors++; $display("FAIL waw_no_stale: got en=%b required 0", rf_write_en); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_pipe(1'b1, 1'b1, 5'd4, 2'd0, 32'h44444444, 32'h0, 32'h0, 3'd4);
    set_md(1'b1, 5'd6, 32'h66666666);
    exp_q.push_back({5'd4, 32'h44444444});
    @(negedge clk);
    rst = 1'b1;
    set_md(1'b0, 5'd0, 32'd0);
    set_pipe(1'b1, 1'b1, 5'd8, 2'd0, 32'h88888888, 32'h0, 32'h0, 3'd4);
    @(posedge clk);
    #1;
    vectors += 2;
    if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_mid_en: got %b required 0", rf_write_en); end
    if (md_ready !== 1'b0) begin errors++; $display("FAIL reset_mid_ready: got %b required 0", md_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    vectors += 2;
    if (rf_write_en !== 1'b0) begin errors++; $display("FAIL reset_mid_discard: got en=%b required 0", rf_write_en); end
    if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready_back: got %b required 1", md_ready); end
  endtask

  task automatic test_random();
    logic       qual, acc, pv, prw, mv;
    logic [4:0] pd, md;
    logic [31:0] pdata, mdata;
    mdl_full = 1'b0;
    mdl_dest = '0;
    mdl_data = '0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      vectors++;
      if (md_ready !== !mdl_full) begin
        errors++;
        $display("FAIL random_md_ready[%0d]: got %b required %b", i, md_ready, !mdl_full);
      end
      pv    = ($urandom_range(0, 3) != 0) && !wb_stall_req;
      prw   = $urandom_range(0, 7) != 0;
      pd    = 5'($urandom_range(0, 3));
      pdata = $urandom;
      mv    = $urandom_range(0, 2) == 0;
      md    = 5'($urandom_range(0, 3));
      mdata = $urandom;
      set_pipe(pv, prw, pd, 2'd0, pdata, 32'h0, 32'h0, 3'd4);
      set_md(mv, md, mdata);
      qual = pv && prw && (pd != 5'd0);
      acc  = mv && !mdl_full;
      if (qual) begin
        exp_q.push_back({pd, pdata});
        if (mdl_full && (pd == mdl_dest)) mdl_full = 1'b0;
      end else if (mdl_full) begin
        exp_q.push_back({mdl_dest, mdl_data});
        mdl_full = 1'b0;
      end
      if (acc && (md != 5'd0)) begin
        mdl_full = 1'b1;
        mdl_dest = md;
        mdl_data = mdata;
      end
    end
    @(negedge clk);
    clear_inputs();
    if (mdl_full) exp_q.push_back({mdl_dest, mdl_data});
    mdl_full = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_zero_dest();
    test_idle_drain();
    test_starvation();
    test_starvation();
    test_waw_drop();
    test_reset_mid();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: got %0d pending writes, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
